// File: rtl/stall_controller.sv
// Pipeline stall/flush sequencer: per-port miss tracking, ROB-pressure stall and a RUN/FLUSH/DRAIN/RECOVER sequence.
// Optional backend-hang watchdog is built only when STALL_WATCHDOG_EN is defined.
module stall_controller #(
    parameter int NUM_MEM_PORTS   = 2,
    parameter int ROB_SIZE        = 64,
    parameter int ROB_ALMOST_FULL = ROB_SIZE - 4,
    parameter int RECOVER_CYCLES  = 3,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            icache_busy,
    input  logic                            overwrite_pc,
    input  logic                            flush_req,
    input  logic [$clog2(ROB_SIZE+1)-1:0]   rob_count,
    input  logic [NUM_MEM_PORTS-1:0]        dmem_busy,
    input  logic [NUM_MEM_PORTS-1:0]        dmem_miss,
    input  logic [NUM_MEM_PORTS-1:0]        dmem_finished,
    input  logic                            store_retire,
    input  logic                            write_finished,
    output logic                            fetch_stall,
    output logic                            frontend_stall,
    output logic                            backend_stall,
    output logic                            retire_stall,
    output logic                            flush,
    output logic [1:0]                      state,
    output logic                            watchdog_timeout
);

    localparam int CW = $clog2(ROB_SIZE + 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        DRAIN   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t                     cur_state;
    logic [3:0]                 recover_cnt;
    logic [NUM_MEM_PORTS-1:0]   pending;
    logic                       store_pend;
    logic                       mem_idle;
    logic                       rob_pressure;
    logic                       not_run;

    assign mem_idle     = ~(|pending) & ~(|dmem_busy);
    assign rob_pressure = rob_count >= CW'(ROB_ALMOST_FULL);
    assign not_run      = cur_state != RUN;

    // A fill completing in the same cycle as a new miss leaves the port clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            store_pend <= 1'b0;
        end else begin
            pending    <= (pending | dmem_miss) & ~dmem_finished;
            store_pend <= store_retire | (store_pend & ~write_finished);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= RUN;
            recover_cnt <= 4'd0;
        end else begin
            case (cur_state)
                RUN: begin
                    if (flush_req) cur_state <= FLUSH;
                end
                FLUSH: begin
                    cur_state <= DRAIN;
                end
                DRAIN: begin
                    if (mem_idle && !store_pend) begin
                        cur_state   <= RECOVER;
                        recover_cnt <= RECOVER_LOAD;
                    end
                end
                RECOVER: begin
                    if (recover_cnt == 4'd0) cur_state <= RUN;
                    else recover_cnt <= recover_cnt - 4'd1;
                end
                default: cur_state <= RUN;
            endcase
        end
    end

    assign state          = cur_state;
    assign flush          = cur_state == FLUSH;
    assign fetch_stall    = reset | not_run | icache_busy | overwrite_pc | rob_pressure;
    assign frontend_stall = reset | not_run | rob_pressure | icache_busy;
    assign backend_stall  = reset | (|pending) | (|dmem_busy) | (|dmem_finished);
    assign retire_stall   = reset | store_pend | (cur_state == FLUSH);

`ifdef STALL_WATCHDOG_EN
    localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
    logic [WDW-1:0] wd_count;

    // Counts consecutive backend-stall cycles; saturates and latches the flag until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_count         <= '0;
            watchdog_timeout <= 1'b0;
        end else if (backend_stall) begin
            if (wd_count != WDW'(WATCHDOG_CYCLES)) wd_count <= wd_count + 1'b1;
            if (wd_count >= WDW'(WATCHDOG_CYCLES - 1)) watchdog_timeout <= 1'b1;
        end else begin
            wd_count <= '0;
        end
    end
`else
    logic unused_watchdog_cfg;
    assign unused_watchdog_cfg = WATCHDOG_CYCLES > 0;
    assign watchdog_timeout    = 1'b0;
`endif

endmodule
